mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from load accept to response valid (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_mem  input  1  load request valid from LSQ.
REQ-006 load_addr  input  32  byte address of load.
REQ-007 load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 load_pd  input  7  destination physical register, echoed on response.
REQ-009 load_rob_tag  input  5  ROB tag, echoed on response.
REQ-010 store_wb  input  1  retired-store write strobe.
REQ-011 store_addr  input  32  byte address of store.
REQ-012 store_data  input  32  store data, LSB-aligned.
REQ-013 store_funct3  input  3  store type: 000 SB, 001 SH, 010 SW.
REQ-014 mispredict  input  1  flush; cancels in-flight load.
REQ-015 load_ready  output  1  responder can accept a load this cycle.
REQ-016 valid  output  1  load response valid, one cycle per load.
REQ-017 data  output  32  extended load result.
REQ-018 p_mem  output  7  echoed load_pd.
REQ-019 rob_tag  output  5  echoed load_rob_tag.

Function
REQ-020 FSM states IDLE, WAIT, RESP; load_ready = (state==IDLE) && !mispredict.
REQ-021 Load accepted when load_mem && load_ready; addr, funct3, pd, rob_tag latched on that edge.
REQ-022 Accept in IDLE -> WAIT with counter = LATENCY-1 (LATENCY=1: directly RESP); WAIT decrements, enters RESP when counter reaches 1.
REQ-023 Accept at cycle N -> valid high at cycle N+LATENCY, for exactly one cycle; RESP -> IDLE unconditionally.
REQ-024 No back-to-back accept: next load accepted earliest in cycle after RESP.
REQ-025 valid = (state==RESP) && !mispredict; data/p_mem/rob_tag = 0 when valid low.
REQ-026 mispredict in WAIT or RESP -> IDLE next edge, latched load discarded, no valid emitted; load_mem in a mispredict cycle ignored.
REQ-027 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher bits ignored (wrap-around aliasing).
REQ-028 Loads: byte lane addr[1:0]; halfword lane addr[1] (addr[0] ignored); word ignores addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; undefined funct3 returns full word.
REQ-029 Stores: write on store_wb edge in any state, never stalled, unaffected by mispredict; SB writes 1 byte lane, SH 2 lanes by addr[1], SW all 4; other funct3 writes nothing.
REQ-030 Load data captured from array on the edge entering RESP; extension applied at capture.
REQ-031 Stores never produce a response; valid is loads only.

Reset
REQ-032 On reset: state IDLE, counter 0, latched request 0, valid 0, data/p_mem/rob_tag 0, load_ready 1 in first cycle after reset deasserts.
REQ-033 On reset: data array cleared to zero.
REQ-034 Reset mid-load (WAIT or RESP) discards the load; no valid after reset.

Configuration
REQ-035 Macro MEM_RESP_FWD_EN defined: store_wb to same word in the capture cycle is byte-merged into captured load data (store wins per written lane).
REQ-036 MEM_RESP_FWD_EN undefined: captured data is pre-store array contents; store still commits.

Verification
REQ-037 Reset, SW 0xDEADBEEF @0x10, LW @0x10 pd=7 tag=3 at N -> valid at N+2, data 0xDEADBEEF, p_mem 7, rob_tag 3.
REQ-038 Word 0x80 = 0x000080F0; LB @0x80 -> 0xFFFFFFF0; LBU @0x81 -> 0x00000080; LH @0x82 -> 0x00000000; LHU @0x80 -> 0x000080F0.
REQ-039 LW accepted, mispredict in WAIT -> no valid, load_ready 1 next cycle; load_mem during mispredict not accepted.
REQ-040 load_mem held high continuously -> accepts every LATENCY+1 cycles; load_ready 0 in WAIT/RESP.
REQ-041 Word 0x20 = 0x11223344, SB 0xAA @0x21 in capture cycle of LW @0x20 -> 0x1122AA44 with MEM_RESP_FWD_EN, 0x11223344 without; later LW returns 0x1122AA44.
REQ-042 DEPTH_WORDS=1024: SW 0x5 @0x1000 then LW @0x0 -> 0x00000005 (wrap).

Source files
------------

// File: rtl/mem_responder_if.sv
// Bundles the load request, retired-store strobe, flush and load response
// signals of mem_responder. The LSQ side uses the master modport and the
// responder uses the slave modport.
interface mem_responder_if;
  logic        load_mem;
  logic [31:0] load_addr;
  logic [2:0]  load_funct3;
  logic [6:0]  load_pd;
  logic [4:0]  load_rob_tag;
  logic        store_wb;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [2:0]  store_funct3;
  logic        mispredict;
  logic        load_ready;
  logic        valid;
  logic [31:0] data;
  logic [6:0]  p_mem;
  logic [4:0]  rob_tag;

  modport master (
    output load_mem, load_addr, load_funct3, load_pd, load_rob_tag,
    output store_wb, store_addr, store_data, store_funct3, mispredict,
    input  load_ready, valid, data, p_mem, rob_tag
  );

  modport slave (
    input  load_mem, load_addr, load_funct3, load_pd, load_rob_tag,
    input  store_wb, store_addr, store_data, store_funct3, mispredict,
    output load_ready, valid, data, p_mem, rob_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency data memory responder. It serves one load at a time with
// LATENCY cycles from accept to a single-cycle response, and it commits
// retired stores every cycle regardless of load state or flush.
// Optional feature macro: MEM_RESP_FWD_EN -- when defined, a store to the
// same word in the load's capture cycle is byte-merged into the load data.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic          clk,
  input logic          reset,
  mem_responder_if.slave bus
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [6:0]    pd_q;
  logic [4:0]    tag_q;
  logic [31:0]   data_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          respValid;
  logic [AW-1:0] capIdx;
  logic [1:0]    capOff;
  logic [2:0]    capF3;
  logic [AW-1:0] stIdx;
  logic [3:0]    stBe;
  logic [31:0]   stLanes;
  logic [31:0]   capWord_d;
  logic [31:0]   data_d;
  logic          unused_addr_bits;

  // Selects the addressed byte or halfword and applies sign/zero extension.
  function automatic logic [31:0] extendLoad(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [7:0]  bSel;
    logic [15:0] hSel;
    bSel = w[{off, 3'b000} +: 8];
    hSel = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extendLoad = {{24{bSel[7]}}, bSel};
      3'b001:  extendLoad = {{16{hSel[15]}}, hSel};
      3'b100:  extendLoad = {24'h0, bSel};
      3'b101:  extendLoad = {16'h0, hSel};
      default: extendLoad = w;
    endcase
  endfunction

  assign accept         = bus.load_mem && bus.load_ready;
  assign bus.load_ready = (state_q == IDLE) && !bus.mispredict;
  assign respValid      = (state_q == RESP) && !bus.mispredict;
  assign bus.valid      = respValid;
  assign bus.data       = respValid ? data_q : 32'h0;
  assign bus.p_mem      = respValid ? pd_q : 7'h0;
  assign bus.rob_tag    = respValid ? tag_q : 5'h0;

  // With single-cycle latency the capture happens on the accept edge, so the
  // request fields come straight from the bus instead of the latched copy.
  assign capIdx = (state_q == IDLE) ? bus.load_addr[AW+1:2] : idx_q;
  assign capOff = (state_q == IDLE) ? bus.load_addr[1:0] : off_q;
  assign capF3  = (state_q == IDLE) ? bus.load_funct3 : f3_q;
  assign stIdx  = bus.store_addr[AW+1:2];

  assign unused_addr_bits = ^{bus.load_addr[31:AW+2], bus.store_addr[31:AW+2]};

  // Decode store type into per-lane write enables and lane-replicated data.
  always_comb begin
    stBe    = 4'b0000;
    stLanes = bus.store_data;
    case (bus.store_funct3)
      3'b000: begin
        stBe    = 4'b0001 << bus.store_addr[1:0];
        stLanes = {4{bus.store_data[7:0]}};
      end
      3'b001: begin
        stBe    = bus.store_addr[1] ? 4'b1100 : 4'b0011;
        stLanes = {2{bus.store_data[15:0]}};
      end
      3'b010:  stBe = 4'b1111;
      default: stBe = 4'b0000;
    endcase
  end

  // Read the word being captured, optionally overlaying a same-cycle store.
  always_comb begin
    capWord_d = mem_q[capIdx];
`ifdef MEM_RESP_FWD_EN
    if (bus.store_wb && (stIdx == capIdx)) begin
      for (int b = 0; b < 4; b++) begin
        if (stBe[b]) capWord_d[8*b +: 8] = stLanes[8*b +: 8];
      end
    end
`endif
    data_d = extendLoad(capWord_d, capOff, capF3);
  end

  // Data array: cleared on reset, otherwise commits retired stores by lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (bus.store_wb) begin
      for (int b = 0; b < 4; b++) begin
        if (stBe[b]) mem_q[stIdx][8*b +: 8] <= stLanes[8*b +: 8];
      end
    end
  end

  // Load sequencer: accept, count down the latency, capture, respond once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      pd_q    <= 7'd0;
      tag_q   <= 5'd0;
      data_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q <= bus.load_addr[AW+1:2];
            off_q <= bus.load_addr[1:0];
            f3_q  <= bus.load_funct3;
            pd_q  <= bus.load_pd;
            tag_q <= bus.load_rob_tag;
            if (LATENCY == 1) begin
              state_q <= RESP;
              data_q  <= data_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (bus.mispredict) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= 4'd0;
            data_q  <= data_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed load-type vectors from a
// table, flush/reset/streaming sequences, and randomized store/load traffic
// checked against a byte-addressed memory model.
module tb_mem_responder;
  localparam int DEPTH     = 1024;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = DEPTH * 4;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] expData;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] modelMem [MEM_BYTES];

  mem_responder_if bus ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic beginCycle();
    @(posedge clk);
    #1;
    bus.load_mem   = 1'b0;
    bus.store_wb   = 1'b0;
    bus.mispredict = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [6:0] pd, input logic [4:0] tag);
    bus.load_mem     = 1'b1;
    bus.load_funct3  = f3;
    bus.load_addr    = addr;
    bus.load_pd      = pd;
    bus.load_rob_tag = tag;
  endtask

  task automatic modelClear();
    for (int i = 0; i < MEM_BYTES; i++) modelMem[i] = 8'h00;
  endtask

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    int a;
    a = int'(addr & 32'(MEM_BYTES - 1));
    case (f3)
      3'b000: modelMem[a] = d[7:0];
      3'b001: begin
        a = a & ~1;
        modelMem[a]   = d[7:0];
        modelMem[a+1] = d[15:8];
      end
      3'b010: begin
        a = a & ~3;
        modelMem[a]   = d[7:0];
        modelMem[a+1] = d[15:8];
        modelMem[a+2] = d[23:16];
        modelMem[a+3] = d[31:24];
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    int v;
    a = int'(addr & 32'(MEM_BYTES - 1));
    case (f3)
      3'b000: begin v = modelMem[a]; if (v >= 128) v = v - 256; end
      3'b100: v = modelMem[a];
      3'b001: begin
        a = a & ~1;
        v = modelMem[a] + 256 * modelMem[a+1];
        if (v >= 32768) v = v - 65536;
      end
      3'b101: begin a = a & ~1; v = modelMem[a] + 256 * modelMem[a+1]; end
      default: begin
        a = a & ~3;
        return {modelMem[a+3], modelMem[a+2], modelMem[a+1], modelMem[a]};
      end
    endcase
    return 32'(v);
  endfunction

  task automatic storeCycle(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    beginCycle();
    bus.store_wb     = 1'b1;
    bus.store_funct3 = f3;
    bus.store_addr   = addr;
    bus.store_data   = d;
    modelStore(f3, addr, d);
  endtask

  task automatic doReset();
    beginCycle();
    reset = 1'b1;
    beginCycle();
    beginCycle();
    reset = 1'b0;
    modelClear();
    settle();
    checkOutput("reset_ready", bus.load_ready, 1);
    checkOutput("reset_valid", bus.valid, 0);
    checkOutput("reset_data", bus.data, 0);
    checkOutput("reset_pmem", bus.p_mem, 0);
    checkOutput("reset_tag", bus.rob_tag, 0);
  endtask

  // One complete load with an optional store in the capture cycle.
  task automatic loadTxn(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [6:0] pd, input logic [4:0] tag,
                         input bit withStore, input logic [2:0] sf3,
                         input logic [31:0] sAddr, input logic [31:0] sData,
                         output logic [31:0] got);
    logic [31:0] exp;
    exp = 32'h0;
    got = 32'hx;
    for (int k = 0; k <= LAT + 1; k++) begin
      beginCycle();
      if (k == 0) applyStimulus(f3, addr, pd, tag);
      if (withStore && (k == LAT - 1)) begin
        bus.store_wb     = 1'b1;
        bus.store_funct3 = sf3;
        bus.store_addr   = sAddr;
        bus.store_data   = sData;
      end
      settle();
      if (k == 0) checkOutput("ready_at_accept", bus.load_ready, 1);
      if (k == LAT - 1) begin
`ifdef MEM_RESP_FWD_EN
        if (withStore) modelStore(sf3, sAddr, sData);
        exp = modelLoad(f3, addr);
`else
        exp = modelLoad(f3, addr);
        if (withStore) modelStore(sf3, sAddr, sData);
`endif
      end
      if (k == LAT) begin
        checkOutput("resp_valid", bus.valid, 1);
        checkOutput("resp_data", bus.data, exp);
        checkOutput("resp_pmem", bus.p_mem, pd);
        checkOutput("resp_tag", bus.rob_tag, tag);
        got = bus.data;
      end else begin
        checkOutput("no_valid", bus.valid, 0);
      end
      if (k == LAT + 1) checkOutput("ready_after_resp", bus.load_ready, 1);
    end
  endtask

  function automatic logic [31:0] randAddr();
    return ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
  endfunction

  initial begin
    vec_t        vecs [9];
    logic [31:0] got;
    logic [31:0] fwdExp;

    reset            = 1'b1;
    bus.load_mem     = 1'b0;
    bus.load_addr    = 32'h0;
    bus.load_funct3  = 3'b010;
    bus.load_pd      = 7'h0;
    bus.load_rob_tag = 5'h0;
    bus.store_wb     = 1'b0;
    bus.store_addr   = 32'h0;
    bus.store_data   = 32'h0;
    bus.store_funct3 = 3'b010;
    bus.mispredict   = 1'b0;

    vecs[0] = '{3'b000, 32'h80, 32'hFFFF_FFF0};
    vecs[1] = '{3'b100, 32'h81, 32'h0000_0080};
    vecs[2] = '{3'b001, 32'h82, 32'h0000_0000};
    vecs[3] = '{3'b101, 32'h80, 32'h0000_80F0};
    vecs[4] = '{3'b001, 32'h80, 32'hFFFF_80F0};
    vecs[5] = '{3'b000, 32'h81, 32'hFFFF_FF80};
    vecs[6] = '{3'b010, 32'h83, 32'h0000_80F0};
    vecs[7] = '{3'b011, 32'h81, 32'h0000_80F0};
    vecs[8] = '{3'b101, 32'h81, 32'h0000_80F0};

    doReset();

    // Basic word store then load with echoed pd/tag.
    storeCycle(3'b010, 32'h10, 32'hDEAD_BEEF);
    loadTxn(3'b010, 32'h10, 7'd7, 5'd3, 1'b0, 3'b0, 32'h0, 32'h0, got);
    checkOutput("basic_lw", got, 32'hDEAD_BEEF);

    // Load type / lane / extension table.
    storeCycle(3'b010, 32'h80, 32'h0000_80F0);
    foreach (vecs[i]) begin
      loadTxn(vecs[i].f3, vecs[i].addr, 7'(i + 10), 5'(i), 1'b0, 3'b0, 32'h0, 32'h0, got);
      checkOutput("table_data", got, vecs[i].expData);
    end

    // Flush in WAIT; a load presented during the flush cycle is ignored.
    for (int k = 0; k <= LAT + 2; k++) begin
      beginCycle();
      if (k == 0) applyStimulus(3'b010, 32'h10, 7'd1, 5'd1);
      if (k == 1) begin
        applyStimulus(3'b010, 32'h10, 7'd2, 5'd2);
        bus.mispredict = 1'b1;
      end
      settle();
      checkOutput("flush_wait_valid", bus.valid, 0);
      if (k == 1) checkOutput("flush_wait_ready", bus.load_ready, 0);
      if (k == 2) checkOutput("flush_wait_ready_after", bus.load_ready, 1);
    end

    // Flush in IDLE together with a load request.
    for (int k = 0; k <= LAT + 1; k++) begin
      beginCycle();
      if (k == 0) begin
        applyStimulus(3'b010, 32'h10, 7'd4, 5'd4);
        bus.mispredict = 1'b1;
      end
      settle();
      if (k == 0) checkOutput("flush_idle_ready", bus.load_ready, 0);
      checkOutput("flush_idle_valid", bus.valid, 0);
    end

    // Flush in the response cycle suppresses valid and zeroes the outputs.
    for (int k = 0; k <= LAT + 1; k++) begin
      beginCycle();
      if (k == 0) applyStimulus(3'b010, 32'h10, 7'd5, 5'd5);
      if (k == LAT) bus.mispredict = 1'b1;
      settle();
      checkOutput("flush_resp_valid", bus.valid, 0);
      if (k == LAT) checkOutput("flush_resp_data", bus.data, 0);
      if (k == LAT + 1) checkOutput("flush_resp_ready", bus.load_ready, 1);
    end

    // Load request held continuously: one accept every LAT+1 cycles.
    for (int t = 0; t < 3 * (LAT + 1); t++) begin
      beginCycle();
      applyStimulus(3'b010, 32'h10, 7'(t), 5'(t));
      settle();
      checkOutput("stream_ready", bus.load_ready, 32'((t % (LAT + 1)) == 0));
      checkOutput("stream_valid", bus.valid, 32'((t % (LAT + 1)) == LAT));
      if ((t % (LAT + 1)) == LAT) begin
        checkOutput("stream_pmem", bus.p_mem, 32'(7'(t - LAT)));
        checkOutput("stream_data", bus.data, modelLoad(3'b010, 32'h10));
      end
    end

    // Same-cycle store into the word being captured.
    storeCycle(3'b010, 32'h20, 32'h1122_3344);
`ifdef MEM_RESP_FWD_EN
    fwdExp = 32'h1122_AA44;
`else
    fwdExp = 32'h1122_3344;
`endif
    loadTxn(3'b010, 32'h20, 7'd9, 5'd9, 1'b1, 3'b000, 32'h21, 32'h0000_00AA, got);
    checkOutput("fwd_capture", got, fwdExp);
    loadTxn(3'b010, 32'h20, 7'd9, 5'd9, 1'b0, 3'b0, 32'h0, 32'h0, got);
    checkOutput("fwd_commit", got, 32'h1122_AA44);

    // Address wrap: upper index bits alias.
    storeCycle(3'b010, 32'h1000, 32'h5);
    loadTxn(3'b010, 32'h0, 7'd11, 5'd11, 1'b0, 3'b0, 32'h0, 32'h0, got);
    checkOutput("wrap_lw", got, 32'h5);

    // Reset in the middle of a load discards it and clears the array.
    beginCycle();
    applyStimulus(3'b010, 32'h10, 7'd6, 5'd6);
    beginCycle();
    reset = 1'b1;
    beginCycle();
    reset = 1'b0;
    modelClear();
    for (int k = 0; k <= LAT + 1; k++) begin
      settle();
      checkOutput("reset_midload_valid", bus.valid, 0);
      beginCycle();
    end
    loadTxn(3'b010, 32'h10, 7'd8, 5'd8, 1'b0, 3'b0, 32'h0, 32'h0, got);
    checkOutput("reset_cleared", got, 32'h0);

    // Randomized traffic against the byte model.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] la;
      logic [31:0] sa;
      int          nst;
      nst = $urandom_range(0, 2);
      for (int s = 0; s < nst; s++)
        storeCycle(3'($urandom_range(0, 3)), randAddr(), $urandom);
      la = randAddr();
      sa = ($urandom_range(0, 1) == 1) ? ((la & ~32'h3) | 32'($urandom_range(0, 3))) : randAddr();
      loadTxn(3'($urandom_range(0, 7)), la, 7'($urandom), 5'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), sa, $urandom, got);
    end

    beginCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
